// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment codes (bit6=g .. bit0=a),
// the blank pattern and the scan-decoder FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG7_0     = 7'b1000000;
  localparam logic [6:0] SEG7_1     = 7'b1111001;
  localparam logic [6:0] SEG7_2     = 7'b0100100;
  localparam logic [6:0] SEG7_3     = 7'b0110000;
  localparam logic [6:0] SEG7_4     = 7'b0011001;
  localparam logic [6:0] SEG7_5     = 7'b0010010;
  localparam logic [6:0] SEG7_6     = 7'b0000010;
  localparam logic [6:0] SEG7_7     = 7'b1011000;
  localparam logic [6:0] SEG7_8     = 7'b0000000;
  localparam logic [6:0] SEG7_9     = 7'b0010000;
  localparam logic [6:0] SEG7_A     = 7'b0001000;
  localparam logic [6:0] SEG7_B     = 7'b0000011;
  localparam logic [6:0] SEG7_C     = 7'b0100111;
  localparam logic [6:0] SEG7_D     = 7'b0100001;
  localparam logic [6:0] SEG7_E     = 7'b0000110;
  localparam logic [6:0] SEG7_F     = 7'b0001110;
  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StWait
  } seg7_state_e;

  // Forward mapping, shared with the hex-to-segment encoder.
  function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = SEG7_0;
      4'h1: seg = SEG7_1;
      4'h2: seg = SEG7_2;
      4'h3: seg = SEG7_3;
      4'h4: seg = SEG7_4;
      4'h5: seg = SEG7_5;
      4'h6: seg = SEG7_6;
      4'h7: seg = SEG7_7;
      4'h8: seg = SEG7_8;
      4'h9: seg = SEG7_9;
      4'hA: seg = SEG7_A;
      4'hB: seg = SEG7_B;
      4'hC: seg = SEG7_C;
      4'hD: seg = SEG7_D;
      4'hE: seg = SEG7_E;
      default: seg = SEG7_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Display-bus interface of the scan decoder: driven segment/anode lines and recovered values.
// Optional decimal-point lines are present when SEG7_DP_EN is defined.
interface seg7_scan_decoder_if #(
  parameter int unsigned DIGITS = 4
) ();

  logic [6:0]          seg_n;
  logic [DIGITS-1:0]   an_n;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   digit_valid;
  logic                update;
  logic                frame_done;
  logic                pat_err;
`ifdef SEG7_DP_EN
  logic                dp_n;
  logic [DIGITS-1:0]   digit_dp;

  modport master (
    output seg_n, an_n, dp_n,
    input  digits, digit_valid, update, frame_done, pat_err, digit_dp
  );

  modport slave (
    input  seg_n, an_n, dp_n,
    output digits, digit_valid, update, frame_done, pat_err, digit_dp
  );
`else
  modport master (
    output seg_n, an_n,
    input  digits, digit_valid, update, frame_done, pat_err
  );

  modport slave (
    input  seg_n, an_n,
    output digits, digit_valid, update, frame_done, pat_err
  );
`endif

endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex encoder: maps an active-low segment pattern
// to its nibble and flags hex codes and the blank pattern.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] nibble,
  output logic       is_hex,
  output logic       is_blank
);

  always_comb begin
    nibble   = 4'h0;
    is_hex   = 1'b1;
    is_blank = 1'b0;
    case (seg_n)
      SEG7_0: nibble = 4'h0;
      SEG7_1: nibble = 4'h1;
      SEG7_2: nibble = 4'h2;
      SEG7_3: nibble = 4'h3;
      SEG7_4: nibble = 4'h4;
      SEG7_5: nibble = 4'h5;
      SEG7_6: nibble = 4'h6;
      SEG7_7: nibble = 4'h7;
      SEG7_8: nibble = 4'h8;
      SEG7_9: nibble = 4'h9;
      SEG7_A: nibble = 4'hA;
      SEG7_B: nibble = 4'hB;
      SEG7_C: nibble = 4'hC;
      SEG7_D: nibble = 4'hD;
      SEG7_E: nibble = 4'hE;
      SEG7_F: nibble = 4'hF;
      SEG7_BLANK: begin
        is_hex   = 1'b0;
        is_blank = 1'b1;
      end
      default: is_hex = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Observer for a multiplexed 7-segment bus: synchronises, settles, votes and commits
// one nibble per digit. Define SEG7_DP_EN to also capture the decimal point.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned MATCH_COUNT   = 3
) (
  input logic                clk,
  input logic                rst_n,
  seg7_scan_decoder_if.slave bus
);

`ifdef SEG7_DP_EN
  localparam int unsigned CodeW = 8;
`else
  localparam int unsigned CodeW = 7;
`endif
  localparam int unsigned IdxW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]         MatchMax   = 4'(MATCH_COUNT);

  logic [CodeW-1:0]  code_raw, code_meta_q, code_sync_q, code_prev_q;
  logic [DIGITS-1:0] an_meta_q, an_sync_q, an_prev_q;

`ifdef SEG7_DP_EN
  assign code_raw = {bus.dp_n, bus.seg_n};
`else
  assign code_raw = bus.seg_n;
`endif

  // Idle bus is all ones, so synchronisers reset high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_meta_q <= '1;
      code_sync_q <= '1;
      code_prev_q <= '1;
      an_meta_q   <= '1;
      an_sync_q   <= '1;
      an_prev_q   <= '1;
    end else begin
      code_meta_q <= code_raw;
      code_sync_q <= code_meta_q;
      code_prev_q <= code_sync_q;
      an_meta_q   <= bus.an_n;
      an_sync_q   <= an_meta_q;
      an_prev_q   <= an_sync_q;
    end
  end

  logic            an_onehot;
  logic [IdxW-1:0] an_idx;
  int unsigned     an_lows;

  always_comb begin
    an_lows = 0;
    an_idx  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_sync_q[i]) begin
        an_lows = an_lows + 1;
        an_idx  = IdxW'(i);
      end
    end
    an_onehot = (an_lows == 1);
  end

  logic [3:0] dec_nibble;
  logic       dec_hex, dec_blank;

  seg7_pattern_decode u_decode (
    .seg_n   (code_sync_q[6:0]),
    .nibble  (dec_nibble),
    .is_hex  (dec_hex),
    .is_blank(dec_blank)
  );

  seg7_state_e               state_q;
  logic [SettleW-1:0]        settle_q;
  logic [IdxW-1:0]           dig_q;
  logic [DIGITS-1:0]         an_lat_q;
  logic [DIGITS-1:0]         seen_q;
  logic [CodeW-1:0]          last_code_q [DIGITS];
  logic [3:0]                match_cnt_q [DIGITS];
  logic [DIGITS-1:0][3:0]    digits_q;
  logic [DIGITS-1:0]         valid_q;
  logic                      update_q, frame_q, pat_err_q;
`ifdef SEG7_DP_EN
  logic [DIGITS-1:0]         dp_q;
`endif

  logic [3:0]        cnt_next;
  logic              voted, dp_chg;
  logic [DIGITS-1:0] seen_next;

  always_comb begin
    if (code_sync_q != last_code_q[dig_q]) begin
      cnt_next = 4'd1;
    end else if (match_cnt_q[dig_q] >= MatchMax) begin
      cnt_next = MatchMax;
    end else begin
      cnt_next = match_cnt_q[dig_q] + 4'd1;
    end
    voted     = (cnt_next == MatchMax);
    seen_next = seen_q | (DIGITS'(1) << dig_q);
`ifdef SEG7_DP_EN
    dp_chg = (dp_q[dig_q] != ~code_sync_q[7]);
`else
    dp_chg = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      settle_q  <= '0;
      dig_q     <= '0;
      an_lat_q  <= '1;
      seen_q    <= '0;
      digits_q  <= '0;
      valid_q   <= '0;
      update_q  <= 1'b0;
      frame_q   <= 1'b0;
      pat_err_q <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        last_code_q[i] <= '1;
        match_cnt_q[i] <= '0;
      end
`ifdef SEG7_DP_EN
      dp_q      <= '0;
`endif
    end else begin
      update_q  <= 1'b0;
      frame_q   <= 1'b0;
      pat_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (an_onehot) begin
            state_q  <= StSettle;
            settle_q <= SettleLoad;
            dig_q    <= an_idx;
            an_lat_q <= an_sync_q;
          end
        end
        StSettle: begin
          if (!an_onehot) begin
            state_q <= StIdle;
          end else if (an_sync_q != an_prev_q || code_sync_q != code_prev_q) begin
            settle_q <= SettleLoad;
            dig_q    <= an_idx;
            an_lat_q <= an_sync_q;
          end else if (settle_q == '0) begin
            state_q <= StSample;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        StSample: begin
          state_q <= StWait;
          if (&seen_next) begin
            frame_q <= 1'b1;
            seen_q  <= '0;
          end else begin
            seen_q <= seen_next;
          end
          if (!dec_hex && !dec_blank) begin
            // Garbage pattern drops the digit at once, without waiting for a vote.
            pat_err_q          <= 1'b1;
            valid_q[dig_q]     <= 1'b0;
            match_cnt_q[dig_q] <= '0;
            update_q           <= valid_q[dig_q];
          end else begin
            last_code_q[dig_q] <= code_sync_q;
            match_cnt_q[dig_q] <= cnt_next;
            if (voted && dec_hex) begin
              digits_q[dig_q] <= dec_nibble;
              valid_q[dig_q]  <= 1'b1;
`ifdef SEG7_DP_EN
              dp_q[dig_q]     <= ~code_sync_q[7];
`endif
              update_q <= !valid_q[dig_q] || (digits_q[dig_q] != dec_nibble) || dp_chg;
            end else if (voted) begin
              valid_q[dig_q] <= 1'b0;
              update_q       <= valid_q[dig_q];
            end
          end
        end
        StWait: begin
          // One sample per dwell: only a new anode pattern re-arms the settle timer.
          if (an_sync_q != an_lat_q) begin
            if (an_onehot) begin
              state_q  <= StSettle;
              settle_q <= SettleLoad;
              dig_q    <= an_idx;
              an_lat_q <= an_sync_q;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.update      = update_q;
  assign bus.frame_done  = frame_q;
  assign bus.pat_err     = pat_err_q;
`ifdef SEG7_DP_EN
  assign bus.digit_dp    = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomised bench for seg7_scan_decoder against a per-dwell voting model.
// Define SEG7_DP_EN to also exercise the decimal-point capture.
module tb_seg7_scan_decoder;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned SETTLE   = 8;
  localparam int unsigned MATCH    = 3;
  localparam int          LONG_MIN = 16;
  localparam logic [6:0]  BLANK    = 7'b1111111;
  localparam logic [6:0]  BAD      = 7'b1111110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_decoder #(
    .DIGITS       (DIGITS),
    .SETTLE_CYCLES(SETTLE),
    .MATCH_COUNT  (MATCH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_checks = 0;
  int n_fail   = 0;
  int obs_upd = 0, obs_frame = 0, obs_pat = 0;
  int exp_upd = 0, exp_frame = 0, exp_pat = 0;

  int m_last [DIGITS];
  int m_cnt  [DIGITS];
  int m_dig  [DIGITS];
  int m_val  [DIGITS];
  int m_dp   [DIGITS];
  int m_seen;

  always @(negedge clk) begin
    if (bus.update)     obs_upd++;
    if (bus.frame_done) obs_frame++;
    if (bus.pat_err)    obs_pat++;
  end

  function automatic void model_reset();
    for (int i = 0; i < DIGITS; i++) begin
      m_last[i] = -1;
      m_cnt[i]  = 0;
      m_dig[i]  = 0;
      m_val[i]  = 0;
      m_dp[i]   = 0;
    end
    m_seen = 0;
  endfunction

  // One sample of digit d: vote over identical consecutive codes, commit at MATCH.
  function automatic void model_sample(input int d, input logic [6:0] code, input logic dpn);
    int idx;
    int key;
    idx = -1;
    for (int k = 0; k < 16; k++) if (hex_tab[k] == code) idx = k;
    key = {dpn, code};
    if (idx < 0 && code != BLANK) begin
      exp_pat++;
      if (m_val[d] != 0) exp_upd++;
      m_val[d] = 0;
      m_cnt[d] = 0;
    end else begin
      if (key == m_last[d]) m_cnt[d] = (m_cnt[d] + 1 > MATCH) ? MATCH : m_cnt[d] + 1;
      else begin
        m_last[d] = key;
        m_cnt[d]  = 1;
      end
      if (m_cnt[d] == MATCH) begin
        if (idx >= 0) begin
          if (m_val[d] == 0 || m_dig[d] != idx || m_dp[d] != int'(!dpn)) exp_upd++;
          m_dig[d] = idx;
          m_val[d] = 1;
          m_dp[d]  = int'(!dpn);
        end else begin
          if (m_val[d] != 0) exp_upd++;
          m_val[d] = 0;
        end
      end
    end
    m_seen = m_seen | (1 << d);
    if (m_seen == (1 << DIGITS) - 1) begin
      exp_frame++;
      m_seen = 0;
    end
  endfunction

  function automatic logic [4*DIGITS-1:0] exp_digits();
    logic [4*DIGITS-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'(m_dig[i]);
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] exp_valid();
    logic [DIGITS-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[i] = (m_val[i] != 0);
    return r;
  endfunction

  task automatic dwell(input int d, input logic [6:0] code, input logic dpn, input int cycles);
    logic [DIGITS-1:0] sel;
    sel = '0;
    sel[d] = 1'b1;
    bus.an_n  = ~sel;
    bus.seg_n = code;
`ifdef SEG7_DP_EN
    bus.dp_n  = dpn;
`endif
    repeat (cycles) @(negedge clk);
    if (cycles >= LONG_MIN) model_sample(d, code, dpn);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks += 5;
    if (bus.digits !== '0) begin
      n_fail++; $display("FAIL reset_digits: got %h want 0", bus.digits);
    end
    if (bus.digit_valid !== '0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", bus.digit_valid);
    end
    if (bus.update !== 1'b0) begin
      n_fail++; $display("FAIL reset_update: got %b want 0", bus.update);
    end
    if (bus.frame_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done);
    end
    if (bus.pat_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_pat_err: got %b want 0", bus.pat_err);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_scan_basic();
    for (int f = 0; f < 3; f++) begin
      for (int d = 0; d < DIGITS; d++) dwell(d, hex_tab[d + 1], 1'b1, 20);
      n_checks++;
      if (bus.digit_valid !== exp_valid()) begin
        n_fail++; $display("FAIL basic_valid_f%0d: got %b want %b", f, bus.digit_valid, exp_valid());
      end
    end
    n_checks += 4;
    if (bus.digits !== 16'h4321) begin
      n_fail++; $display("FAIL basic_digits: got %h want 4321", bus.digits);
    end
    if (bus.digit_valid !== 4'hF) begin
      n_fail++; $display("FAIL basic_all_valid: got %b want 1111", bus.digit_valid);
    end
    if (obs_upd !== 4 || obs_upd !== exp_upd) begin
      n_fail++; $display("FAIL basic_update_count: got %0d want %0d", obs_upd, exp_upd);
    end
    if (obs_frame !== 3 || obs_frame !== exp_frame) begin
      n_fail++; $display("FAIL basic_frame_count: got %0d want %0d", obs_frame, exp_frame);
    end
  endtask

  task automatic test_toggle();
    for (int f = 0; f < 4; f++) begin
      for (int d = 0; d < DIGITS; d++)
        dwell(d, (d == 2) ? hex_tab[(f % 2 == 1) ? 6 : 5] : hex_tab[d + 1], 1'b1, 20);
      n_checks += 3;
      if (bus.digits[11:8] !== 4'h3) begin
        n_fail++; $display("FAIL toggle_hold_f%0d: got %h want 3", f, bus.digits[11:8]);
      end
      if (bus.digits !== exp_digits() || bus.digit_valid !== exp_valid()) begin
        n_fail++; $display("FAIL toggle_model_f%0d: got %h/%b want %h/%b", f, bus.digits,
                           bus.digit_valid, exp_digits(), exp_valid());
      end
      if (obs_upd !== exp_upd) begin
        n_fail++; $display("FAIL toggle_updates_f%0d: got %0d want %0d", f, obs_upd, exp_upd);
      end
    end
  endtask

  task automatic test_invalid();
    logic [DIGITS-1:0]   v0;
    logic [4*DIGITS-1:0] d0;
    int                  p0;
    v0 = bus.digit_valid;
    d0 = bus.digits;
    p0 = obs_pat;
    for (int d = 0; d < DIGITS; d++) dwell(d, (d == 1) ? BAD : hex_tab[d + 1], 1'b1, 20);
    n_checks += 4;
    if (obs_pat - p0 !== 1 || obs_pat !== exp_pat) begin
      n_fail++; $display("FAIL invalid_pat_err: got %0d pulses want 1", obs_pat - p0);
    end
    if (bus.digit_valid[1] !== 1'b0) begin
      n_fail++; $display("FAIL invalid_valid1: got %b want 0", bus.digit_valid[1]);
    end
    if ((bus.digit_valid & 4'b1101) !== (v0 & 4'b1101) || bus.digits !== d0) begin
      n_fail++; $display("FAIL invalid_others: got %h/%b want %h/%b", bus.digits,
                         bus.digit_valid, d0, v0 & 4'b1101);
    end
    if (obs_upd !== exp_upd) begin
      n_fail++; $display("FAIL invalid_updates: got %0d want %0d", obs_upd, exp_upd);
    end
  endtask

  task automatic test_short_dwell();
    logic [DIGITS-1:0]   v0;
    logic [4*DIGITS-1:0] d0;
    int                  u0, f0, p0;
    v0 = bus.digit_valid;
    d0 = bus.digits;
    u0 = obs_upd;
    f0 = obs_frame;
    p0 = obs_pat;
    for (int n = 0; n < 8; n++)
      dwell(n % DIGITS, (n % 2 == 0) ? BAD : hex_tab[$urandom_range(0, 15)], 1'b1, 5);
    n_checks += 4;
    if (bus.digits !== d0 || bus.digit_valid !== v0) begin
      n_fail++; $display("FAIL short_hold: got %h/%b want %h/%b", bus.digits, bus.digit_valid,
                         d0, v0);
    end
    if (obs_frame !== f0) begin
      n_fail++; $display("FAIL short_frame: got %0d want %0d", obs_frame, f0);
    end
    if (obs_pat !== p0) begin
      n_fail++; $display("FAIL short_pat_err: got %0d want %0d", obs_pat, p0);
    end
    if (obs_upd !== u0) begin
      n_fail++; $display("FAIL short_update: got %0d want %0d", obs_upd, u0);
    end
  endtask

  task automatic test_two_low();
    int f0, p0;
    f0 = obs_frame;
    p0 = obs_pat;
    bus.an_n  = 4'b0011;
    bus.seg_n = BAD;
    repeat (30) @(negedge clk);
    n_checks += 2;
    if (obs_pat !== p0) begin
      n_fail++; $display("FAIL two_low_pat_err: got %0d want %0d", obs_pat, p0);
    end
    if (obs_frame !== f0) begin
      n_fail++; $display("FAIL two_low_frame: got %0d want %0d", obs_frame, f0);
    end
  endtask

  task automatic test_random();
    int         base [DIGITS];
    int         d, r, len;
    logic [6:0] code;
    for (int i = 0; i < DIGITS; i++) base[i] = $urandom_range(0, 15);
    d = 0;
    for (int n = 0; n < 48; n++) begin
      r = $urandom_range(0, 99);
      if (r < 65)      code = hex_tab[base[d]];
      else if (r < 75) code = hex_tab[$urandom_range(0, 15)];
      else if (r < 85) code = BLANK;
      else if (r < 92) code = BAD;
      else begin
        base[d] = $urandom_range(0, 15);
        code    = hex_tab[base[d]];
      end
      len = ($urandom_range(0, 99) < 15) ? $urandom_range(3, 6) : $urandom_range(18, 26);
      dwell(d, code, 1'b1, len);
      if (len >= LONG_MIN) begin
        n_checks += 2;
        if (bus.digits !== exp_digits()) begin
          n_fail++; $display("FAIL rand_digits_%0d: got %h want %h", n, bus.digits, exp_digits());
        end
        if (bus.digit_valid !== exp_valid()) begin
          n_fail++; $display("FAIL rand_valid_%0d: got %b want %b", n, bus.digit_valid,
                             exp_valid());
        end
      end
      d = (d + 1) % DIGITS;
    end
    n_checks += 3;
    if (obs_upd !== exp_upd) begin
      n_fail++; $display("FAIL rand_updates: got %0d want %0d", obs_upd, exp_upd);
    end
    if (obs_frame !== exp_frame) begin
      n_fail++; $display("FAIL rand_frames: got %0d want %0d", obs_frame, exp_frame);
    end
    if (obs_pat !== exp_pat) begin
      n_fail++; $display("FAIL rand_pat_err: got %0d want %0d", obs_pat, exp_pat);
    end
  endtask

  task automatic test_reset_mid_settle();
    bus.an_n = '1;
    repeat (3) @(negedge clk);
    bus.an_n  = 4'b1110;
    bus.seg_n = hex_tab[1];
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks += 2;
    if (bus.digits !== '0 || bus.digit_valid !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h/%b want 0/0", bus.digits, bus.digit_valid);
    end
    if (bus.update !== 1'b0 || bus.frame_done !== 1'b0 || bus.pat_err !== 1'b0) begin
      n_fail++; $display("FAIL midreset_pulses: got %b%b%b want 000", bus.update,
                         bus.frame_done, bus.pat_err);
    end
    model_reset();
    bus.an_n = '1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      for (int d = 0; d < DIGITS; d++) dwell(d, hex_tab[d + 5], 1'b1, 20);
      n_checks++;
      if (bus.digit_valid !== ((f == 2) ? 4'hF : 4'h0)) begin
        n_fail++; $display("FAIL midreset_vote_f%0d: got %b want %b", f, bus.digit_valid,
                           (f == 2) ? 4'hF : 4'h0);
      end
    end
    n_checks += 2;
    if (bus.digits !== 16'h8765) begin
      n_fail++; $display("FAIL midreset_digits: got %h want 8765", bus.digits);
    end
    if (obs_upd !== exp_upd || obs_frame !== exp_frame) begin
      n_fail++; $display("FAIL midreset_counts: got %0d/%0d want %0d/%0d", obs_upd, obs_frame,
                         exp_upd, exp_frame);
    end
  endtask

`ifdef SEG7_DP_EN
  task automatic test_dp();
    for (int f = 0; f < 3; f++)
      for (int d = 0; d < DIGITS; d++)
        dwell(d, hex_tab[(d == 0) ? 8 : d], (d == 0) ? 1'b0 : 1'b1, 20);
    n_checks += 2;
    if (bus.digits[3:0] !== 4'h8 || bus.digit_dp[0] !== 1'b1) begin
      n_fail++; $display("FAIL dp_digit0: got %h/%b want 8/1", bus.digits[3:0], bus.digit_dp[0]);
    end
    if (bus.digit_dp !== 4'b0001) begin
      n_fail++; $display("FAIL dp_mask: got %b want 0001", bus.digit_dp);
    end
  endtask
`endif

  initial begin
    bus.an_n  = '1;
    bus.seg_n = BLANK;
`ifdef SEG7_DP_EN
    bus.dp_n  = 1'b1;
`endif
    model_reset();
    test_reset();
    test_scan_basic();
    test_toggle();
    test_invalid();
    test_short_dwell();
    test_two_low();
    test_random();
    test_reset_mid_settle();
`ifdef SEG7_DP_EN
    test_dp();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
